// File: rtl/unified_cache_mem_responder_pkg.sv
// Shared packet layout and FSM encoding for the unified cache memory responder.
// Field positions describe the to-mem / from-mem packet as seen on both channels.
package unified_cache_mem_responder_pkg;

    localparam int UNIFIED_CACHE_BLOCK_SIZE_IN_BITS = 512;
    localparam int UNIFIED_CACHE_ADDR_WIDTH         = 32;
    localparam int UNIFIED_CACHE_PORT_NUM_WIDTH     = 4;

    localparam int UNIFIED_CACHE_PACKET_DATA_LO     = 0;
    localparam int UNIFIED_CACHE_PACKET_DATA_HI     = UNIFIED_CACHE_BLOCK_SIZE_IN_BITS - 1;
    localparam int UNIFIED_CACHE_PACKET_ADDR_LO     = UNIFIED_CACHE_PACKET_DATA_HI + 1;
    localparam int UNIFIED_CACHE_PACKET_ADDR_HI     = UNIFIED_CACHE_PACKET_ADDR_LO + UNIFIED_CACHE_ADDR_WIDTH - 1;
    localparam int UNIFIED_CACHE_PACKET_PORT_NUM_LO = UNIFIED_CACHE_PACKET_ADDR_HI + 1;
    localparam int UNIFIED_CACHE_PACKET_PORT_NUM_HI = UNIFIED_CACHE_PACKET_PORT_NUM_LO + UNIFIED_CACHE_PORT_NUM_WIDTH - 1;
    localparam int UNIFIED_CACHE_PACKET_IS_WRITE_POS = UNIFIED_CACHE_PACKET_PORT_NUM_HI + 1;
    localparam int UNIFIED_CACHE_PACKET_VALID_POS    = UNIFIED_CACHE_PACKET_IS_WRITE_POS + 1;
    localparam int UNIFIED_CACHE_PACKET_WIDTH_IN_BITS = UNIFIED_CACHE_PACKET_VALID_POS + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESPOND = 2'd2,
        ST_WRITE   = 2'd3
    } state_t;

endpackage

// File: rtl/unified_cache_mem_responder_if.sv
// To-mem / from-mem packet channels between the cache (master) and the memory responder (slave).
interface unified_cache_mem_responder_if;

    logic [unified_cache_mem_responder_pkg::UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0] to_mem_packet_in;
    logic                                                                         to_mem_packet_ack_out;
    logic [unified_cache_mem_responder_pkg::UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0] from_mem_packet_out;
    logic                                                                         from_mem_packet_ack_in;

    modport master (
        output to_mem_packet_in,
        output from_mem_packet_ack_in,
        input  to_mem_packet_ack_out,
        input  from_mem_packet_out
    );

    modport slave (
        input  to_mem_packet_in,
        input  from_mem_packet_ack_in,
        output to_mem_packet_ack_out,
        output from_mem_packet_out
    );

endinterface

// File: rtl/unified_cache_mem_responder_mem_array.sv
// Block-granular backing store: synchronous write, combinational read, never cleared.
module unified_cache_mem_array #(
    parameter int NUM_BLOCK  = 1024,
    parameter int WIDTH      = 512,
    parameter int IDX_W      = $clog2(NUM_BLOCK)
) (
    input  logic             clk_in,
    input  logic             we_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] store_q [NUM_BLOCK];

    always_ff @(posedge clk_in) begin
        if (we_i) begin
            store_q[idx_i] <= wdata_i;
        end
    end

    assign rdata_o = store_q[idx_i];

endmodule

// File: rtl/unified_cache_mem_responder.sv
// Memory-side responder: captures one miss/writeback at a time, commits writes,
// and returns read fills MEM_LATENCY cycles after the capture ack.
module unified_cache_mem_responder
    import unified_cache_mem_responder_pkg::*;
#(
    parameter int BLOCK_SIZE  = 64,
    parameter int NUM_BLOCK   = 1024,
    parameter int MEM_LATENCY = 8
) (
    input  logic                          clk_in,
    input  logic                          reset_in,
    unified_cache_mem_responder_if.slave  mem_if
);

    localparam int PKT_W  = UNIFIED_CACHE_PACKET_WIDTH_IN_BITS;
    localparam int BLK_W  = BLOCK_SIZE * 8;
    localparam int OFF_W  = $clog2(BLOCK_SIZE);
    localparam int IDX_W  = $clog2(NUM_BLOCK);
    localparam int CNT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    state_t             state_q;
    logic [PKT_W-1:0]   req_q;
    logic [PKT_W-1:0]   resp_q;
    logic [PKT_W-1:0]   resp_d;
    logic               ack_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   blk_idx;
    logic [BLK_W-1:0]   rd_data;
    logic               store_we;

    // Upper address bits are dropped, so the store aliases every NUM_BLOCK blocks.
    assign blk_idx  = req_q[UNIFIED_CACHE_PACKET_ADDR_LO + OFF_W +: IDX_W];
    assign store_we = (state_q == ST_WRITE);

    unified_cache_mem_array #(
        .NUM_BLOCK (NUM_BLOCK),
        .WIDTH     (BLK_W),
        .IDX_W     (IDX_W)
    ) u_mem_array (
        .clk_in  (clk_in),
        .we_i    (store_we),
        .idx_i   (blk_idx),
        .wdata_i (req_q[UNIFIED_CACHE_PACKET_DATA_LO +: BLK_W]),
        .rdata_o (rd_data)
    );

    always_comb begin
        resp_d = req_q;
        resp_d[UNIFIED_CACHE_PACKET_DATA_LO +: BLK_W]  = rd_data;
        resp_d[UNIFIED_CACHE_PACKET_IS_WRITE_POS]      = 1'b0;
        resp_d[UNIFIED_CACHE_PACKET_VALID_POS]         = 1'b1;
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            resp_q  <= '0;
            ack_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (mem_if.to_mem_packet_in[UNIFIED_CACHE_PACKET_VALID_POS]) begin
                        req_q <= mem_if.to_mem_packet_in;
                        ack_q <= 1'b1;
                        if (mem_if.to_mem_packet_in[UNIFIED_CACHE_PACKET_IS_WRITE_POS]) begin
                            state_q <= ST_WRITE;
                        end else begin
                            cnt_q   <= CNT_W'(MEM_LATENCY - 1);
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WRITE: begin
                    state_q <= ST_IDLE;
                end
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        resp_q  <= resp_d;
                        state_q <= ST_RESPOND;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_RESPOND: begin
                    if (mem_if.from_mem_packet_ack_in) begin
                        resp_q  <= '0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem_if.to_mem_packet_ack_out = ack_q;
    assign mem_if.from_mem_packet_out   = resp_q;

endmodule

// File: tb/tb_unified_cache_mem_responder.sv
// Directed bench for the memory responder: latency, backpressure, ordering, aliasing, reset.
module tb_unified_cache_mem_responder;
    import unified_cache_mem_responder_pkg::*;

    localparam int PKT_W = UNIFIED_CACHE_PACKET_WIDTH_IN_BITS;
    localparam int BLK_W = UNIFIED_CACHE_BLOCK_SIZE_IN_BITS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    unified_cache_mem_responder_if bus ();
    unified_cache_mem_responder_if bus1 ();

    unified_cache_mem_responder #(.BLOCK_SIZE(64), .NUM_BLOCK(1024), .MEM_LATENCY(8)) dut (
        .clk_in   (clk),
        .reset_in (rst),
        .mem_if   (bus)
    );

    unified_cache_mem_responder #(.BLOCK_SIZE(64), .NUM_BLOCK(1024), .MEM_LATENCY(1)) dut1 (
        .clk_in   (clk),
        .reset_in (rst),
        .mem_if   (bus1)
    );

    function automatic logic [BLK_W-1:0] blk(input logic [7:0] b);
        return {64{b}};
    endfunction

    function automatic logic [PKT_W-1:0] mk_pkt(input logic v, input logic w, input logic [31:0] addr,
                                                 input logic [3:0] port, input logic [BLK_W-1:0] data);
        logic [PKT_W-1:0] p;
        p = '0;
        p[UNIFIED_CACHE_PACKET_VALID_POS]    = v;
        p[UNIFIED_CACHE_PACKET_IS_WRITE_POS] = w;
        p[UNIFIED_CACHE_PACKET_ADDR_HI:UNIFIED_CACHE_PACKET_ADDR_LO]         = addr;
        p[UNIFIED_CACHE_PACKET_PORT_NUM_HI:UNIFIED_CACHE_PACKET_PORT_NUM_LO] = port;
        p[UNIFIED_CACHE_PACKET_DATA_HI:UNIFIED_CACHE_PACKET_DATA_LO]         = data;
        return p;
    endfunction

    function automatic logic [7:0] pat(input int i);
        case (i)
            0:       return 8'h10;
            1:       return 8'hA5;
            2:       return 8'h22;
            default: return 8'h33;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [PKT_W-1:0] obs, input logic [PKT_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] b);
        bus.to_mem_packet_in = mk_pkt(1'b1, 1'b1, addr, 4'd0, blk(b));
        tick();
        chk("wr_ack", bus.to_mem_packet_ack_out, 1);
        bus.to_mem_packet_in = '0;
        tick();
        chk("wr_ack_pulse", bus.to_mem_packet_ack_out, 0);
        $display("write addr=%h byte=%h", addr, b);
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr, input logic [3:0] port, input logic [7:0] b);
        logic got;
        int   lat;
        got = 1'b0;
        lat = 0;
        bus.to_mem_packet_in = mk_pkt(1'b1, 1'b0, addr, port, '0);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.to_mem_packet_ack_out) begin
                got = 1'b1;
                break;
            end
        end
        chk({tag, "_ack_seen"}, got, 1);
        bus.to_mem_packet_in = '0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.from_mem_packet_out[UNIFIED_CACHE_PACKET_VALID_POS]) begin
                lat = i;
                break;
            end
        end
        chk({tag, "_latency"}, lat, 8);
        chk({tag, "_pkt"}, bus.from_mem_packet_out, mk_pkt(1'b1, 1'b0, addr, port, blk(b)));
        bus.from_mem_packet_ack_in = 1'b1;
        tick();
        bus.from_mem_packet_ack_in = 1'b0;
        chk({tag, "_cleared"}, bus.from_mem_packet_out, '0);
        $display("read addr=%h port=%0d latency=%0d", addr, port, lat);
    endtask

    initial begin
        logic [PKT_W-1:0] snap;
        logic             stable;
        logic             early;
        logic             quiet;
        int               lat;
        int               acks;
        int               sidx;
        int               ridx;
        int               ack_cyc [4];

        bus.to_mem_packet_in        = '0;
        bus.from_mem_packet_ack_in  = 1'b0;
        bus1.to_mem_packet_in       = '0;
        bus1.from_mem_packet_ack_in = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_ack", bus.to_mem_packet_ack_out, 0);
        chk("rst_out", bus.from_mem_packet_out, '0);
        chk("rst_out_l1", bus1.from_mem_packet_out, '0);
        rst = 1'b0;
        tick();

        // Test 1: write then read 0x40
        for (int i = 0; i < 4; i++) do_write(32'(i * 64), pat(i));
        do_write(32'h0000_FFC0, 8'h5C);
        do_read("t1", 32'h40, 4'd1, 8'hA5);

        // Test 2: backpressure on fill, second request held waiting
        bus.to_mem_packet_in = mk_pkt(1'b1, 1'b0, 32'hC0, 4'd2, '0);
        tick();
        chk("bp_ackA", bus.to_mem_packet_ack_out, 1);
        bus.to_mem_packet_in = '0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.from_mem_packet_out[UNIFIED_CACHE_PACKET_VALID_POS]) begin
                lat = i;
                break;
            end
        end
        chk("bp_latA", lat, 8);
        chk("bp_pktA", bus.from_mem_packet_out, mk_pkt(1'b1, 1'b0, 32'hC0, 4'd2, blk(8'h33)));
        snap   = bus.from_mem_packet_out;
        stable = 1'b1;
        early  = 1'b0;
        bus.to_mem_packet_in = mk_pkt(1'b1, 1'b0, 32'h80, 4'd3, '0);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.from_mem_packet_out !== snap) stable = 1'b0;
            if (bus.to_mem_packet_ack_out) early = 1'b1;
        end
        chk("bp_stable", stable, 1);
        chk("bp_no_early_ack", early, 0);
        bus.from_mem_packet_ack_in = 1'b1;
        tick();
        bus.from_mem_packet_ack_in = 1'b0;
        chk("bp_fill_cleared", bus.from_mem_packet_out, '0);
        chk("bp_no_ack_on_fill_edge", bus.to_mem_packet_ack_out, 0);
        tick();
        chk("bp_ackB", bus.to_mem_packet_ack_out, 1);
        tick();
        chk("bp_no_recapture", bus.to_mem_packet_ack_out, 0);
        bus.to_mem_packet_in = '0;
        lat = 1;
        for (int i = 2; i <= 20; i++) begin
            tick();
            if (bus.from_mem_packet_out[UNIFIED_CACHE_PACKET_VALID_POS]) begin
                lat = i;
                break;
            end
        end
        chk("bp_latB", lat, 8);
        chk("bp_pktB", bus.from_mem_packet_out, mk_pkt(1'b1, 1'b0, 32'h80, 4'd3, blk(8'h22)));
        bus.from_mem_packet_ack_in = 1'b1;
        tick();
        bus.from_mem_packet_ack_in = 1'b0;
        $display("backpressure read addr=c0 then addr=80");

        // Test 3: four back-to-back reads, requests held continuously valid
        acks = 0;
        sidx = 0;
        ridx = 0;
        bus.to_mem_packet_in = mk_pkt(1'b1, 1'b0, 32'h0, 4'd0, '0);
        for (int c = 0; c < 200 && ridx < 4; c++) begin
            tick();
            bus.from_mem_packet_ack_in = 1'b0;
            if (bus.to_mem_packet_ack_out) begin
                acks++;
                if (sidx < 4) ack_cyc[sidx] = c;
                sidx++;
                bus.to_mem_packet_in = (sidx < 4) ? mk_pkt(1'b1, 1'b0, 32'(sidx * 64), 4'(sidx), '0) : '0;
            end
            if (bus.from_mem_packet_out[UNIFIED_CACHE_PACKET_VALID_POS]) begin
                chk("b2b_pkt", bus.from_mem_packet_out, mk_pkt(1'b1, 1'b0, 32'(ridx * 64), 4'(ridx), blk(pat(ridx))));
                chk("b2b_latency", c - ack_cyc[ridx], 8);
                $display("b2b read idx=%0d ack_cycle=%0d resp_cycle=%0d", ridx, ack_cyc[ridx], c);
                bus.from_mem_packet_ack_in = 1'b1;
                ridx++;
            end
        end
        tick();
        bus.from_mem_packet_ack_in = 1'b0;
        bus.to_mem_packet_in = '0;
        quiet = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.to_mem_packet_ack_out || bus.from_mem_packet_out[UNIFIED_CACHE_PACKET_VALID_POS]) quiet = 1'b0;
        end
        chk("b2b_ack_count", acks, 4);
        chk("b2b_resp_count", ridx, 4);
        chk("b2b_quiet", quiet, 1);

        // Test 4: aliasing past NUM_BLOCK
        do_read("alias", 32'h0001_FFC0, 4'd3, 8'h5C);

        // Test 5: reset during WAIT drops the read
        bus.to_mem_packet_in = mk_pkt(1'b1, 1'b0, 32'h80, 4'd2, '0);
        tick();
        chk("rstw_ack", bus.to_mem_packet_ack_out, 1);
        bus.to_mem_packet_in = '0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("rstw_ack_low", bus.to_mem_packet_ack_out, 0);
        chk("rstw_out_zero", bus.from_mem_packet_out, '0);
        rst = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.to_mem_packet_ack_out || bus.from_mem_packet_out[UNIFIED_CACHE_PACKET_VALID_POS]) quiet = 1'b0;
        end
        chk("rstw_no_response", quiet, 1);
        do_read("rstw_survive", 32'h40, 4'd1, 8'hA5);

        // Test 6: MEM_LATENCY=1 instance
        bus1.to_mem_packet_in = mk_pkt(1'b1, 1'b1, 32'h100, 4'd0, blk(8'h77));
        tick();
        chk("l1_wr_ack", bus1.to_mem_packet_ack_out, 1);
        bus1.to_mem_packet_in = '0;
        tick();
        bus1.to_mem_packet_in = mk_pkt(1'b1, 1'b0, 32'h100, 4'd5, '0);
        tick();
        chk("l1_rd_ack", bus1.to_mem_packet_ack_out, 1);
        chk("l1_not_yet", bus1.from_mem_packet_out[UNIFIED_CACHE_PACKET_VALID_POS], 0);
        bus1.to_mem_packet_in = '0;
        tick();
        chk("l1_pkt", bus1.from_mem_packet_out, mk_pkt(1'b1, 1'b0, 32'h100, 4'd5, blk(8'h77)));
        bus1.from_mem_packet_ack_in = 1'b1;
        tick();
        bus1.from_mem_packet_ack_in = 1'b0;
        chk("l1_cleared", bus1.from_mem_packet_out, '0);
        $display("latency-1 read addr=100 port=5");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/unified_cache_mem_responder.md
Name: unified_cache_mem_responder

Overview:
Memory-side responder for the unified cache's to-mem / from-mem packet interface.
- Accepts miss (read) and writeback (write) packets issued by the cache's to-mem arbiter.
- Services them against an internal block-granular backing store after a programmable latency.
- Returns read-fill packets on the from-mem channel.
- Serves as the memory model in cache-level benches and as the template for the real memory controller front end.

Parameters:
UNIFIED_CACHE_PACKET_WIDTH_IN_BITS, `UNIFIED_CACHE_PACKET_WIDTH_IN_BITS, width of one packet
BLOCK_SIZE, 64, cache block size in bytes; data field is BLOCK_SIZE*8 bits
NUM_BLOCK, 1024, backing-store depth in blocks (power of two)
MEM_LATENCY, 8, cycles from request capture to read-response valid (>=1)

Ports:
clk_in  input  1  clock
reset_in  input  1  synchronous, active-high reset
to_mem_packet_in  input  UNIFIED_CACHE_PACKET_WIDTH_IN_BITS  request from cache; valid at `UNIFIED_CACHE_PACKET_VALID_POS
to_mem_packet_ack_out  output  1  one-cycle pulse: request captured
from_mem_packet_out  output  UNIFIED_CACHE_PACKET_WIDTH_IN_BITS  fill packet to cache; valid bit inside packet
from_mem_packet_ack_in  input  1  cache has consumed the fill packet

Behaviour:
Reset (checked on the clock edge while reset_in=1):
- to_mem_packet_ack_out=0; from_mem_packet_out=all zeros (valid=0).
- FSM returns to IDLE; latency counter=0.
- Backing store is not cleared; contents survive reset.
- Reset overrides every other event in the same cycle; an in-flight request is dropped with no response.

Packet fields (positions from parameters.h): VALID_POS, IS_WRITE_POS, ADDR_LO/HI, DATA_LO/HI, PORT_NUM_LO.

Address mapping: block index = addr[$clog2(BLOCK_SIZE) +: $clog2(NUM_BLOCK)]. Upper address bits are ignored, so the store aliases.

FSM states: IDLE, WAIT, RESPOND, WRITE.

IDLE:
- If the request valid bit is 1 at a clock edge, capture the whole packet into req_reg.
- Assert to_mem_packet_ack_out=1 for the following cycle only.
- Go to WRITE if is_write=1, else load counter=MEM_LATENCY-1 and go to WAIT.

WRITE:
- Write the data field into store[index] at the next edge, then return to IDLE.
- No response packet is generated for writes.

WAIT:
- Decrement the counter each cycle.
- On the edge where the counter is 0, build the response into from_mem_packet_out and go to RESPOND. The response is req_reg with:
  - data replaced by store[index];
  - is_write=0;
  - valid=1;
  - address and port number unchanged.
- Read latency: the response is valid exactly MEM_LATENCY cycles after the ack cycle.

RESPOND:
- Hold from_mem_packet_out stable until from_mem_packet_ack_in=1 is sampled.
- On that edge, clear the output valid bit and the packet, then go to IDLE.
- An ack seen in any other state is ignored.

Ordering and concurrency:
- Only one request is outstanding at a time. No new request is acked outside IDLE, so the sender holds its packet (backpressure).
- After returning to IDLE, a new request may be captured in the very next cycle.
- A request that is still valid on the edge after its ack (sender not yet dropped) is NOT re-captured. The FSM is in WAIT/WRITE at that point, so this is structurally guaranteed.
- Read-after-write to the same block returns the new data: WRITE commits before IDLE re-accepts.

Decomposition:
Shared package / parameters.h:
- packet field position macros;
- UNIFIED_CACHE_BLOCK_SIZE_IN_BITS;
- FSM state encoding constants (2-bit: IDLE=0, WAIT=1, RESPOND=2, WRITE=3).

One sub-module: unified_cache_mem_array.
- NUM_BLOCK x BLOCK_SIZE*8 storage.
- Synchronous write, asynchronous read.
- No reset.

Test Plan:
1. Write then read: write addr 0x40, data pattern A5 repeated; after the ack, read addr 0x40 (port 1). The response arrives exactly 8 cycles after the read ack, with data A5 repeated, port=1, valid=1.
2. Backpressure: hold from_mem_packet_ack_in=0 for 20 cycles on a read. The output stays stable; a second request held valid gets no ack until 1 cycle after the fill ack is given.
3. Back-to-back: hold 4 reads to indices 0..3 continuously valid. Each gets exactly one ack pulse with no duplicate capture; responses come in order, each 8 cycles after its ack.
4. Aliasing/wrap: write index NUM_BLOCK-1, then read address + NUM_BLOCK*BLOCK_SIZE. The read returns the same data.
5. Reset mid-read: assert reset_in during WAIT. The next cycle has ack=0, output valid=0, no response ever; a subsequent read of a previously written block returns the pre-reset data.
6. MEM_LATENCY=1 build: the response is valid the cycle after the ack.
